mandelbrot_iterator: RTL

MANDELBROT_ITERATOR -- requirements
Module: mandelbrot_iterator

---
 rtl/mandelbrot_pkg.sv | 22 ++
 rtl/mandelbrot_step.sv | 68 ++++++
 rtl/mandelbrot_iterator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_pkg
// Description : Shared definitions for the Mandelbrot point iterator:
//               default fixed-point geometry, iteration counter width
//               and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mandelbrot_pkg;

  localparam int DEF_COORD_W = 12;  // c input width, Q(COORD_W-FRAC).FRAC
  localparam int DEF_FRAC    = 9;   // fractional bits of every value
  localparam int ITER_W      = 6;   // iteration counter / limit width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mandelbrot_step.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_step
// Description : One combinational z <- z^2 + c step plus the |z|^2 > 4
//               escape test, evaluated on the current z.
// Ports       : zr_i, zi_i       current z (COORD_W+2 bits, signed)
//               c_re_i, c_im_i   point c (COORD_W bits, signed)
//               escape_o         1 when zr^2 + zi^2 > 4.0 (exact)
//               zr_next_o        zr^2 - zi^2 + c_re
//               zi_next_o        2*zr*zi + c_im
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_step
  import mandelbrot_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int FRAC    = DEF_FRAC
) (
  input  logic signed [COORD_W+1:0] zr_i,
  input  logic signed [COORD_W+1:0] zi_i,
  input  logic signed [COORD_W-1:0] c_re_i,
  input  logic signed [COORD_W-1:0] c_im_i,
  output logic                      escape_o,
  output logic signed [COORD_W+1:0] zr_next_o,
  output logic signed [COORD_W+1:0] zi_next_o
);

  localparam int ZW = COORD_W + 2;
  localparam int PW = 2 * ZW;
  // One bit above the product width so that the doubled cross product
  // (|2*zr*zi| can reach 2^(PW-1)) and the magnitude sum never wrap.
  localparam int SW = PW + 1;

  // 4.0 expressed in the unshifted product scale (2*FRAC fractional bits).
  localparam logic signed [SW-1:0] c_FOUR =
    {{(SW - 2*FRAC - 3){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

  logic signed [SW-1:0] w_zr_x, w_zi_x, w_cre_x, w_cim_x;
  logic signed [SW-1:0] w_zr2, w_zi2, w_zrzi, w_cross, w_mag;
  logic signed [SW-1:0] w_zr_sum, w_zi_sum;
  logic                 w_unused_hi;

  assign w_zr_x  = {{(SW-ZW){zr_i[ZW-1]}}, zr_i};
  assign w_zi_x  = {{(SW-ZW){zi_i[ZW-1]}}, zi_i};
  assign w_cre_x = {{(SW-COORD_W){c_re_i[COORD_W-1]}}, c_re_i};
  assign w_cim_x = {{(SW-COORD_W){c_im_i[COORD_W-1]}}, c_im_i};

  assign w_zr2   = w_zr_x * w_zr_x;
  assign w_zi2   = w_zi_x * w_zi_x;
  assign w_zrzi  = w_zr_x * w_zi_x;
  assign w_cross = w_zrzi <<< 1;

  // Escape test on the full-precision sum, no truncation.
  assign w_mag    = w_zr2 + w_zi2;
  assign escape_o = (w_mag > c_FOUR);

  // Each product is rescaled by an arithmetic shift (floor) before c is added.
  assign w_zr_sum = (w_zr2 >>> FRAC) - (w_zi2 >>> FRAC) + w_cre_x;
  assign w_zi_sum = (w_cross >>> FRAC) + w_cim_x;

  // Any point that has not escaped has |z| <= 2 and |c| < 4, so the next z
  // stays inside the two guard integer bits; the upper bits are redundant.
  assign zr_next_o   = w_zr_sum[ZW-1:0];
  assign zi_next_o   = w_zi_sum[ZW-1:0];
  assign w_unused_hi = ^{w_zr_sum[SW-1:ZW], w_zi_sum[SW-1:ZW]};

endmodule
`default_nettype wire

// File: rtl/mandelbrot_iterator.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_iterator
// Description : Iterates z <- z^2 + c for one point until |z|^2 > 4 or the
//               iteration limit is hit, then reports the escape count.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               start             request a new point (taken in IDLE only)
//               c_re, c_im        point c, sampled on an accepted start
//               max_iter          iteration limit, sampled on accepted start
//               busy              high in ITER and DONE
//               done              one-cycle result-valid pulse
//               iteration_count   escape count (or the limit if in the set)
//               in_set            limit reached without escape
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_iterator
  import mandelbrot_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int FRAC    = DEF_FRAC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] c_re,
  input  logic signed [COORD_W-1:0] c_im,
  input  logic        [ITER_W-1:0]  max_iter,
  output logic                      busy,
  output logic                      done,
  output logic        [ITER_W-1:0]  iteration_count,
  output logic                      in_set
);

  localparam int ZW = COORD_W + 2;

  state_t                    state_q, state_d;
  logic signed [ZW-1:0]      zr_q, zr_d, zi_q, zi_d;
  logic signed [COORD_W-1:0] cre_q, cre_d, cim_q, cim_d;
  logic        [ITER_W-1:0]  n_q, n_d, max_q, max_d;
  logic        [ITER_W-1:0]  count_q, count_d;
  logic                      inset_q, inset_d;

  logic                      w_escape;
  logic signed [ZW-1:0]      w_zr_next, w_zi_next;

  mandelbrot_step #(
    .COORD_W (COORD_W),
    .FRAC    (FRAC)
  ) u_step (
    .zr_i      (zr_q),
    .zi_i      (zi_q),
    .c_re_i    (cre_q),
    .c_im_i    (cim_q),
    .escape_o  (w_escape),
    .zr_next_o (w_zr_next),
    .zi_next_o (w_zi_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cre_q   <= '0;
      cim_q   <= '0;
      n_q     <= '0;
      max_q   <= '0;
      count_q <= '0;
      inset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cre_q   <= cre_d;
      cim_q   <= cim_d;
      n_q     <= n_d;
      max_q   <= max_d;
      count_q <= count_d;
      inset_q <= inset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cre_d   = cre_q;
    cim_d   = cim_q;
    n_d     = n_q;
    max_d   = max_q;
    count_d = count_q;
    inset_d = inset_q;
    busy    = 1'b1;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cre_d   = c_re;
          cim_d   = c_im;
          max_d   = max_iter;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        // Escape takes priority over the limit: a point escaping exactly at
        // n == max_iter is reported as escaped.
        if (w_escape) begin
          count_d = n_q;
          inset_d = 1'b0;
          state_d = ST_DONE;
        end else if (n_q == max_q) begin
          count_d = max_q;
          inset_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          zr_d = w_zr_next;
          zi_d = w_zi_next;
          n_d  = n_q + 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign iteration_count = count_q;
  assign in_set          = inset_q;

endmodule
`default_nettype wire
